// File: rtl/jogo_memoria_parametrizado.sv
`default_nettype none
// ============================================================================
// Module   : jogo_memoria_parametrizado
// Purpose  : memory-sequence game with LFSR-filled buffer, progressive
//            playback rounds and per-press timeout.
//            Optional feature macro: TIMEOUT_REPLAY_EN (one replay per game).
// Revision : 1.0
// ============================================================================
module jogo_memoria_parametrizado #(
    parameter int          N_CH     = 4,
    parameter int          MAX_SEQ  = 16,
    parameter int          T_ON     = 1000,
    parameter int          T_OFF    = 500,
    parameter int          T_LIMITE = 3000,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            jogar,
    input  logic            nivel,
    input  logic [N_CH-1:0] botoes,
    output logic [N_CH-1:0] leds,
    output logic            pronto,
    output logic            ganhou,
    output logic            perdeu,
    output logic            timeout,
    output logic [3:0]      db_estado,
    output logic [5:0]      db_rodada,
    output logic [5:0]      db_endereco,
    output logic [N_CH-1:0] db_memoria
);
    localparam int AW    = $clog2(MAX_SEQ);
    localparam int T_A   = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int T_MAX = (T_LIMITE > T_A) ? T_LIMITE : T_A;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'h0,
        S_GERA       = 4'h1,
        S_MOSTRA_ON  = 4'h2,
        S_MOSTRA_OFF = 4'h3,
        S_ESPERA     = 4'h4,
        S_COMPARA    = 4'h5,
        S_PROXIMA    = 4'h6,
        S_GANHOU     = 4'hA,
        S_TIMEOUT    = 4'hD,
        S_PERDEU     = 4'hE
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [15:0]     lfsr_q;
    logic [N_CH-1:0] botoes_q;
    logic [N_CH-1:0] jogada_q, jogada_d;
    logic [5:0]      rodada_q, rodada_d;
    logic [5:0]      end_q, end_d;
    logic [6:0]      comp_q, comp_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [N_CH-1:0] leds_q, leds_d;
    logic            pronto_q, pronto_d, ganhou_q, ganhou_d;
    logic            perdeu_q, perdeu_d, timeout_q, timeout_d;
`ifdef TIMEOUT_REPLAY_EN
    logic            replay_q, replay_d;
`endif

    logic [N_CH-1:0] buffer_q [MAX_SEQ];
    logic [N_CH-1:0] mem_rd, entrada;
    logic [7:0]      sel;
    logic            tem_jogada, grava, terminal;

    assign sel        = lfsr_q[7:0] % 8'(N_CH);
    assign entrada    = {{(N_CH-1){1'b0}}, 1'b1} << sel;
    assign mem_rd     = buffer_q[end_q[AW-1:0]];
    assign tem_jogada = |(botoes & ~botoes_q);
    assign terminal   = (estado_q == S_GANHOU) || (estado_q == S_PERDEU) ||
                        (estado_q == S_TIMEOUT);

    always_comb begin
        estado_d  = estado_q;
        jogada_d  = jogada_q;
        rodada_d  = rodada_q;
        end_d     = end_q;
        comp_d    = comp_q;
        timer_d   = timer_q + TW'(1);
        grava     = 1'b0;
`ifdef TIMEOUT_REPLAY_EN
        replay_d  = replay_q;
`endif
        case (estado_q)
            S_IDLE, S_GANHOU, S_PERDEU, S_TIMEOUT: begin
                timer_d = '0;
                if (jogar) begin
                    comp_d   = nivel ? 7'(MAX_SEQ) : 7'(MAX_SEQ / 2);
                    end_d    = '0;
                    rodada_d = '0;
                    estado_d = S_GERA;
`ifdef TIMEOUT_REPLAY_EN
                    replay_d = 1'b0;
`endif
                end
            end
            S_GERA: begin
                grava   = 1'b1;
                timer_d = '0;
                if ({1'b0, end_q} == comp_q - 7'd1) begin
                    end_d    = '0;
                    estado_d = S_MOSTRA_ON;
                end else begin
                    end_d = end_q + 6'd1;
                end
            end
            S_MOSTRA_ON: begin
                if (timer_q == TW'(T_ON - 1)) begin
                    timer_d  = '0;
                    estado_d = S_MOSTRA_OFF;
                end
            end
            S_MOSTRA_OFF: begin
                if (timer_q == TW'(T_OFF - 1)) begin
                    timer_d = '0;
                    if (end_q == rodada_q) begin
                        end_d    = '0;
                        estado_d = S_ESPERA;
                    end else begin
                        end_d    = end_q + 6'd1;
                        estado_d = S_MOSTRA_ON;
                    end
                end
            end
            S_ESPERA: begin
                // a press on the limit cycle still wins over the timeout
                if (tem_jogada) begin
                    jogada_d = botoes;
                    timer_d  = '0;
                    estado_d = S_COMPARA;
                end else if (timer_q == TW'(T_LIMITE - 1)) begin
                    timer_d  = '0;
`ifdef TIMEOUT_REPLAY_EN
                    if (!replay_q) begin
                        replay_d = 1'b1;
                        end_d    = '0;
                        estado_d = S_MOSTRA_ON;
                    end else begin
                        estado_d = S_TIMEOUT;
                    end
`else
                    estado_d = S_TIMEOUT;
`endif
                end
            end
            S_COMPARA: begin
                timer_d = '0;
                if (jogada_q != mem_rd) begin
                    estado_d = S_PERDEU;
                end else if (end_q != rodada_q) begin
                    end_d    = end_q + 6'd1;
                    estado_d = S_ESPERA;
                end else if ({1'b0, rodada_q} == comp_q - 7'd1) begin
                    estado_d = S_GANHOU;
                end else begin
                    estado_d = S_PROXIMA;
                end
            end
            S_PROXIMA: begin
                timer_d  = '0;
                rodada_d = rodada_q + 6'd1;
                end_d    = '0;
                estado_d = S_MOSTRA_ON;
            end
            default: begin
                timer_d  = '0;
                estado_d = S_IDLE;
            end
        endcase

        leds_d    = (estado_q == S_MOSTRA_ON) ? mem_rd : '0;
        pronto_d  = terminal;
        ganhou_d  = (estado_q == S_GANHOU);
        perdeu_d  = (estado_q == S_PERDEU) || (estado_q == S_TIMEOUT);
        timeout_d = (estado_q == S_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= S_IDLE;
            lfsr_q    <= SEED;
            botoes_q  <= '0;
            jogada_q  <= '0;
            rodada_q  <= '0;
            end_q     <= '0;
            comp_q    <= '0;
            timer_q   <= '0;
            leds_q    <= '0;
            pronto_q  <= 1'b0;
            ganhou_q  <= 1'b0;
            perdeu_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef TIMEOUT_REPLAY_EN
            replay_q  <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            botoes_q  <= botoes;
            jogada_q  <= jogada_d;
            rodada_q  <= rodada_d;
            end_q     <= end_d;
            comp_q    <= comp_d;
            timer_q   <= timer_d;
            leds_q    <= leds_d;
            pronto_q  <= pronto_d;
            ganhou_q  <= ganhou_d;
            perdeu_q  <= perdeu_d;
            timeout_q <= timeout_d;
`ifdef TIMEOUT_REPLAY_EN
            replay_q  <= replay_d;
`endif
        end
    end

    // sequence storage survives reset on purpose
    always_ff @(posedge clock) begin
        if (reset && grava) begin
            buffer_q[end_q[AW-1:0]] <= entrada;
        end
    end

    assign leds        = leds_q;
    assign pronto      = pronto_q;
    assign ganhou      = ganhou_q;
    assign perdeu      = perdeu_q;
    assign timeout     = timeout_q;
    assign db_estado   = estado_q;
    assign db_rodada   = rodada_q;
    assign db_endereco = end_q;
    assign db_memoria  = mem_rd;

endmodule
`default_nettype wire
